uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter CLKS_PER_TICK, default 27, SHALL set clk cycles per 16x-oversample tick (bit period = 16*CLKS_PER_TICK clks); legal range 2..1023.
- REQ-002: Parameter PARITY_ODD, default 0, SHALL select the expected parity: 0 = even, 1 = odd.
- REQ-003: clk  input  1  single system clock; all state SHALL update on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: rx  input  1  asynchronous serial line; idle high.
- REQ-006: rx_data  output  8  last received data byte.
- REQ-007: rx_valid  output  1  one-clk pulse marking a completed frame.
- REQ-008: parity_err  output  1  parity mismatch flag for the frame in rx_data.
- REQ-009: frame_err  output  1  stop-bit-low flag for the frame in rx_data.
- REQ-010: busy  output  1  high whenever the state is not IDLE.

Function
- REQ-011: The frame format SHALL be 11 bits: start (0), data[0]..data[7] (LSB first), parity, stop (1).
- REQ-012: rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s.
- REQ-013: The tick divider SHALL be held at 0 in IDLE, start counting on start detection, and pulse tick for one clk each CLKS_PER_TICK clks.
- REQ-014: A 4-bit oversample counter SHALL count ticks within a bit; a 3-bit bit index SHALL track data bits 0..7.
- REQ-015: States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
- REQ-016: IDLE -> START when rx_s = 0; oversample counter cleared.
- REQ-017: START: at oversample count 7 (mid-bit), rx_s = 1 SHALL return to IDLE (false start, no rx_valid); rx_s = 0 SHALL clear the counter and enter DATA.
- REQ-018: DATA: at each oversample count 15 (mid-bit), rx_s SHALL be shifted into bit [index] of a shift register; after index 7 -> PARITY.
- REQ-019: PARITY: at count 15, sample the parity bit; expected = XOR(data) XOR PARITY_ODD; mismatch is latched internally -> STOP.
- REQ-020: STOP: at count 15, sample the stop bit; on the next clk rx_data SHALL load the shift register, parity_err and frame_err SHALL update, and rx_valid SHALL pulse for exactly one clk.
- REQ-021: After STOP, stop = 1 SHALL go to IDLE immediately (mid-stop-bit), so back-to-back frames are accepted; stop = 0 SHALL set frame_err and go to BREAK.
- REQ-022: BREAK SHALL wait until rx_s = 1 and then return to IDLE, with no further rx_valid.
- REQ-023: rx_data, parity_err and frame_err SHALL hold their values until the next rx_valid.
- REQ-024: A frame with an error SHALL still deliver rx_data and pulse rx_valid.
- REQ-025: Latency SHALL be: rx_valid high 2 clks after the tick that samples stop-bit mid (1 sample, 1 register).

Reset
- REQ-026: On rst_n low, asynchronously: state = IDLE, counters = 0, shift register = 0, synchronizer = 1, rx_data = 8'h00, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
- REQ-027: Reset asserted mid-frame SHALL abort the frame with no rx_valid; after release the block SHALL wait for a new falling edge (a line still low SHALL be treated as a start).

Verification (CLKS_PER_TICK = 4, bit = 64 clks, PARITY_ODD = 0)
- REQ-028: Send 8'hA5 with parity 0 and stop 1 -> single rx_valid pulse, rx_data = 8'hA5, parity_err = 0, frame_err = 0, busy low after.
- REQ-029: Send 8'h01 with parity 0 (wrong; expected 1) -> rx_valid pulse, rx_data = 8'h01, parity_err = 1, frame_err = 0.
- REQ-030: Send 8'h3C with stop = 0, then hold rx low for 5 bit periods -> rx_valid pulse, frame_err = 1; busy stays high until rx returns high, then no extra rx_valid.
- REQ-031: rx low for 20 clks, then high -> busy pulse only; no rx_valid; outputs unchanged.
- REQ-032: Two frames 8'h55, 8'hAA back-to-back with no idle gap -> two rx_valid pulses with correct data, no errors.
- REQ-033: Assert rst_n low in the middle of data bit 4 -> all outputs at reset values; the next full frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver with 16x oversampling. Frame is 11 bits:
//   start (0), data[0..7] LSB first, parity, stop (1).
//   The line is brought into the clock domain through a 2-flop synchronizer;
//   all decoding uses the synchronized value rx_s.
//
// Parameters
//   CLKS_PER_TICK : clk cycles per oversample tick (bit = 16*CLKS_PER_TICK clks),
//                   legal range 2..1023
//   PARITY_ODD    : 0 = even parity expected, 1 = odd parity expected
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  last received data byte (held until next rx_valid)
//   rx_valid   out  one-clk pulse per completed frame (also for errored frames)
//   parity_err out  parity mismatch flag for the frame in rx_data
//   frame_err  out  stop-bit-low flag for the frame in rx_data
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_TICK = 27,
    parameter int PARITY_ODD    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_W = 10;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_TICK - 1);
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Registers
    state_t           state_q,      state_d;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [DIV_W-1:0] div_q,        div_d;
    logic [3:0]       os_q,         os_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       shift_q,      shift_d;
    logic             par_mis_q,    par_mis_d;
    logic             stop_bit_q,   stop_bit_d;
    logic             done_q,       done_d;
    logic [7:0]       rx_data_q,    rx_data_d;
    logic             rx_valid_q,   rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q,  frame_err_d;

    logic tick;

    // Divider only runs while a frame is in progress, so a tick is only
    // meaningful outside IDLE.
    assign tick = (state_q != IDLE) && (div_q == DIV_LAST);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        os_d         = os_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        stop_bit_d   = stop_bit_q;
        done_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = done_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        // Tick divider: held at 0 in IDLE, free-running otherwise
        if (state_q == IDLE) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                os_d      = 4'd0;
                bit_idx_d = 3'd0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == 4'd7) begin
                        // Middle of the start bit: a high line here is a glitch
                        os_d    = 4'd0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    // os wraps 15 -> 0 on its own, keeping bit-to-bit spacing exact
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        shift_d[bit_idx_q] = rx_s_q;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = PARITY;
                        end
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        par_mis_d = rx_s_q ^ (^shift_q) ^ PAR_ODD_BIT;
                        state_d   = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        // Leave mid-stop-bit so an immediately following start
                        // edge is not missed.
                        done_d     = 1'b1;
                        stop_bit_d = rx_s_q;
                        state_d    = rx_s_q ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Publish the frame one clk after the stop sample
        if (done_q) begin
            rx_data_d    = shift_q;
            parity_err_d = par_mis_q;
            frame_err_d  = ~stop_bit_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            div_q        <= '0;
            os_q         <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_mis_q    <= 1'b0;
            stop_bit_q   <= 1'b1;
            done_q       <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            div_q        <= div_d;
            os_q         <= os_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            stop_bit_q   <= stop_bit_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with CLKS_PER_TICK = 4 (bit = 64 clks) and even
//   parity. Inputs are driven on the falling edge; outputs are observed on the
//   falling edge. A monitor counts rx_valid pulses and captures each frame.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic [7:0] cap_data [0:15];
    logic       cap_perr [0:15];
    logic       cap_ferr [0:15];

    uart_rx #(
        .CLKS_PER_TICK(4),
        .PARITY_ODD   (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid === 1'b1) begin
            cap_data[valid_cnt[3:0]] = rx_data;
            cap_perr[valid_cnt[3:0]] = parity_err;
            cap_ferr[valid_cnt[3:0]] = frame_err;
            last_valid_cyc = cyc;
            valid_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Called on a falling edge; drives one complete 11-bit frame
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        $display("sent frame data=%02h parity=%0b stop=%0b", d, par, stp);
    endtask

    int v0;

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_data",  32'(rx_data),    32'h00);
        chk("rst_rx_valid", 32'(rx_valid),   32'h0);
        chk("rst_par_err",  32'(parity_err), 32'h0);
        chk("rst_frm_err",  32'(frame_err),  32'h0);
        chk("rst_busy",     32'(busy),       32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0xA5 (four ones -> even parity bit 0)
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("a5_pulses",  32'(valid_cnt - v0), 32'd1);
        chk("a5_data",    32'(rx_data),        32'hA5);
        chk("a5_par_err", 32'(parity_err),     32'h0);
        chk("a5_frm_err", 32'(frame_err),      32'h0);
        chk("a5_busy",    32'(busy),           32'h0);
        // 2 sync + 1 detect + 8 ticks start + 10*64 data/parity/stop... -> 676
        chk("a5_latency", 32'(last_valid_cyc - start_cyc), 32'd676);

        // 0x01 needs parity 1 for even; send 0
        v0 = valid_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("p01_pulses",  32'(valid_cnt - v0), 32'd1);
        chk("p01_data",    32'(rx_data),        32'h01);
        chk("p01_par_err", 32'(parity_err),     32'h1);
        chk("p01_frm_err", 32'(frame_err),      32'h0);

        // 0x3C with stop low, then line held low (break)
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (5 * BIT_CLKS) @(negedge clk);
        chk("brk_busy_low", 32'(busy),           32'h1);
        chk("brk_pulses",   32'(valid_cnt - v0), 32'd1);
        chk("brk_data",     32'(rx_data),        32'h3C);
        chk("brk_frm_err",  32'(frame_err),      32'h1);
        chk("brk_par_err",  32'(parity_err),     32'h0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("brk_busy_rel", 32'(busy), 32'h0);
        repeat (100) @(negedge clk);
        chk("brk_no_extra", 32'(valid_cnt - v0), 32'd1);

        // False start: 20 clks low
        v0 = valid_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("fs_busy", 32'(busy), 32'h1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("fs_busy_after", 32'(busy),           32'h0);
        chk("fs_no_valid",   32'(valid_cnt - v0), 32'd0);
        chk("fs_data_held",  32'(rx_data),        32'h3C);
        chk("fs_ferr_held",  32'(frame_err),      32'h1);

        // Back-to-back 0x55, 0xAA
        v0 = valid_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("b2b_pulses", 32'(valid_cnt - v0),       32'd2);
        chk("b2b_data0",  32'(cap_data[v0 & 15]),     32'h55);
        chk("b2b_err0",   32'({cap_perr[v0 & 15], cap_ferr[v0 & 15]}), 32'h0);
        chk("b2b_data1",  32'(cap_data[(v0 + 1) & 15]), 32'hAA);
        chk("b2b_err1",   32'({parity_err, frame_err}), 32'h0);

        // Reset in the middle of data bit 4
        v0 = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data",  32'(rx_data),  32'h00);
        chk("mid_rst_valid", 32'(rx_valid), 32'h0);
        chk("mid_rst_busy",  32'(busy),     32'h0);
        chk("mid_rst_errs",  32'({parity_err, frame_err}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("mid_no_valid", 32'(valid_cnt - v0), 32'd0);
        v0 = valid_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("5a_pulses", 32'(valid_cnt - v0), 32'd1);
        chk("5a_data",   32'(rx_data),        32'h5A);
        chk("5a_errs",   32'({parity_err, frame_err}), 32'h0);
        chk("5a_busy",   32'(busy),           32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
